sa_read_channel: RTL and testbench



---
 rtl/axi_interconnect_pkg.sv | 21 ++
 rtl/sa_rd_order_fifo.sv | 71 +++++++
 rtl/sa_read_channel.sv | 177 +++++++++++++++++
 tb/tb_sa_read_channel.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_interconnect_pkg.sv
// Shared constants and types for the AXI interconnect read path.
// Field widths, the master-index width helper and the AR FSM encoding.
package axi_interconnect_pkg;

  localparam int DFLT_ID_W    = 5;
  localparam int DFLT_BURST_W = 2;
  localparam int DFLT_LEN_W   = 3;
  localparam int DFLT_SIZE_W  = 3;
  localparam int DFLT_RESP_W  = 2;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_HOLD = 1'b1
  } ar_state_e;

  // A single master still needs a 1-bit index so that vectors stay legal.
  function automatic int calc_mst_id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sa_rd_order_fifo.sv
// Order FIFO recording which master owns each outstanding read burst.
// Push on slave AR acceptance, pop on the slave's RLAST handshake.
module sa_rd_order_fifo #(
  parameter int DEPTH   = 8,
  parameter int ENTRY_W = 1,
  parameter int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] push_data_i,
  input  logic               pop_i,
  output logic [ENTRY_W-1:0] head_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [CNT_W-1:0]   count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/sa_read_channel.sv
// Slave-side read channel: round-robin AR arbitration toward one slave port
// and in-order steering of the slave's R bursts back to the owning master.
module sa_read_channel
  import axi_interconnect_pkg::*;
#(
  parameter int MST_AMT           = 2,
  parameter int OUTSTANDING_AMT   = 8,
  parameter int DATA_WIDTH        = 32,
  parameter int ADDR_WIDTH        = 32,
  parameter int TRANS_MST_ID_W    = DFLT_ID_W,
  parameter int TRANS_BURST_W     = DFLT_BURST_W,
  parameter int TRANS_DATA_LEN_W  = DFLT_LEN_W,
  parameter int TRANS_DATA_SIZE_W = DFLT_SIZE_W,
  parameter int TRANS_WR_RESP_W   = DFLT_RESP_W
) (
  input  logic                                    ACLK_i,
  input  logic                                    ARESETn_i,
  input  logic [TRANS_MST_ID_W*MST_AMT-1:0]       dsp_ARID_i,
  input  logic [ADDR_WIDTH*MST_AMT-1:0]           dsp_ARADDR_i,
  input  logic [TRANS_BURST_W*MST_AMT-1:0]        dsp_ARBURST_i,
  input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]     dsp_ARLEN_i,
  input  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0]    dsp_ARSIZE_i,
  input  logic [MST_AMT-1:0]                      dsp_ARVALID_i,
  input  logic [MST_AMT-1:0]                      dsp_AR_outst_full_i,
  output logic [MST_AMT-1:0]                      dsp_ARREADY_o,
  output logic [TRANS_MST_ID_W*MST_AMT-1:0]       dsp_RID_o,
  output logic [DATA_WIDTH*MST_AMT-1:0]           dsp_RDATA_o,
  output logic [TRANS_WR_RESP_W*MST_AMT-1:0]      dsp_RRESP_o,
  output logic [MST_AMT-1:0]                      dsp_RLAST_o,
  output logic [MST_AMT-1:0]                      dsp_RVALID_o,
  input  logic [MST_AMT-1:0]                      dsp_RREADY_i,
  output logic [TRANS_MST_ID_W-1:0]               s_ARID_o,
  output logic [ADDR_WIDTH-1:0]                   s_ARADDR_o,
  output logic [TRANS_BURST_W-1:0]                s_ARBURST_o,
  output logic [TRANS_DATA_LEN_W-1:0]             s_ARLEN_o,
  output logic [TRANS_DATA_SIZE_W-1:0]            s_ARSIZE_o,
  output logic                                    s_ARVALID_o,
  input  logic                                    s_ARREADY_i,
  input  logic [TRANS_MST_ID_W-1:0]               s_RID_i,
  input  logic [DATA_WIDTH-1:0]                   s_RDATA_i,
  input  logic [TRANS_WR_RESP_W-1:0]              s_RRESP_i,
  input  logic                                    s_RLAST_i,
  input  logic                                    s_RVALID_i,
  output logic                                    s_RREADY_o
);

  localparam int MST_ID_W = calc_mst_id_w(MST_AMT);
  localparam int CNT_W    = $clog2(OUTSTANDING_AMT) + 1;

  ar_state_e                      state_q, state_d;
  logic [MST_ID_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic [MST_ID_W-1:0]            grant_q, grant_d;
  logic [TRANS_MST_ID_W-1:0]      arid_q, arid_d;
  logic [ADDR_WIDTH-1:0]          araddr_q, araddr_d;
  logic [TRANS_BURST_W-1:0]       arburst_q, arburst_d;
  logic [TRANS_DATA_LEN_W-1:0]    arlen_q, arlen_d;
  logic [TRANS_DATA_SIZE_W-1:0]   arsize_q, arsize_d;

  logic [MST_AMT-1:0]  cand;
  logic                found;
  logic [MST_ID_W-1:0] win;
  int                  idx;
  logic                ar_grant;
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [MST_ID_W-1:0] head;
  logic [CNT_W-1:0]    fifo_count;

  assign cand = dsp_ARVALID_i & ~dsp_AR_outst_full_i;

  // Round-robin: first candidate at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < MST_AMT; i++) begin
      idx = (int'(rr_ptr_q) + i) % MST_AMT;
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = MST_ID_W'(idx);
      end
    end
  end

  assign ar_grant      = (state_q == AR_IDLE) & found & ~fifo_full & ARESETn_i;
  assign dsp_ARREADY_o = ar_grant ? (MST_AMT'(1) << win) : '0;
  assign fifo_push     = (state_q == AR_HOLD) & s_ARREADY_i;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    arid_d    = arid_q;
    araddr_d  = araddr_q;
    arburst_d = arburst_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    case (state_q)
      AR_IDLE: begin
        if (ar_grant) begin
          state_d   = AR_HOLD;
          grant_d   = win;
          rr_ptr_d  = (win == MST_ID_W'(MST_AMT - 1)) ? '0 : win + 1'b1;
          arid_d    = dsp_ARID_i[int'(win)*TRANS_MST_ID_W +: TRANS_MST_ID_W];
          araddr_d  = dsp_ARADDR_i[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
          arburst_d = dsp_ARBURST_i[int'(win)*TRANS_BURST_W +: TRANS_BURST_W];
          arlen_d   = dsp_ARLEN_i[int'(win)*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
          arsize_d  = dsp_ARSIZE_i[int'(win)*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
        end
      end
      AR_HOLD: begin
        if (s_ARREADY_i) begin
          state_d = AR_IDLE;
        end
      end
      default: state_d = AR_IDLE;
    endcase
  end

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      state_q   <= AR_IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arburst_q <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      arid_q    <= arid_d;
      araddr_q  <= araddr_d;
      arburst_q <= arburst_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
    end
  end

  assign s_ARVALID_o = (state_q == AR_HOLD);
  assign s_ARID_o    = arid_q;
  assign s_ARADDR_o  = araddr_q;
  assign s_ARBURST_o = arburst_q;
  assign s_ARLEN_o   = arlen_q;
  assign s_ARSIZE_o  = arsize_q;

  sa_rd_order_fifo #(
    .DEPTH   (OUTSTANDING_AMT),
    .ENTRY_W (MST_ID_W),
    .CNT_W   (CNT_W)
  ) u_order_fifo (
    .clk         (ACLK_i),
    .rst_n       (ARESETn_i),
    .push_i      (fifo_push),
    .push_data_i (grant_q),
    .pop_i       (fifo_pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // R beats without an owner (empty FIFO) are stalled, never forwarded.
  assign dsp_RVALID_o = (s_RVALID_i & ~fifo_empty) ? (MST_AMT'(1) << head) : '0;
  assign s_RREADY_o   = ~fifo_empty & dsp_RREADY_i[head];
  assign fifo_pop     = s_RVALID_i & s_RREADY_o & s_RLAST_i;

  assign dsp_RID_o   = {MST_AMT{s_RID_i}};
  assign dsp_RDATA_o = {MST_AMT{s_RDATA_i}};
  assign dsp_RRESP_o = {MST_AMT{s_RRESP_i}};
  assign dsp_RLAST_o = {MST_AMT{s_RLAST_i}};

  logic unused_ok;
  assign unused_ok = ^fifo_count;

endmodule

// File: tb/tb_sa_read_channel.sv
// Directed self-checking bench for sa_read_channel (2 masters, depth 8).
module tb_sa_read_channel;

  localparam int M  = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int IW = 5;

  logic            ACLK_i = 1'b0;
  logic            ARESETn_i;
  logic [IW*M-1:0] dsp_ARID_i;
  logic [AW*M-1:0] dsp_ARADDR_i;
  logic [2*M-1:0]  dsp_ARBURST_i;
  logic [3*M-1:0]  dsp_ARLEN_i;
  logic [3*M-1:0]  dsp_ARSIZE_i;
  logic [M-1:0]    dsp_ARVALID_i;
  logic [M-1:0]    dsp_AR_outst_full_i;
  logic [M-1:0]    dsp_ARREADY_o;
  logic [IW*M-1:0] dsp_RID_o;
  logic [DW*M-1:0] dsp_RDATA_o;
  logic [2*M-1:0]  dsp_RRESP_o;
  logic [M-1:0]    dsp_RLAST_o;
  logic [M-1:0]    dsp_RVALID_o;
  logic [M-1:0]    dsp_RREADY_i;
  logic [IW-1:0]   s_ARID_o;
  logic [AW-1:0]   s_ARADDR_o;
  logic [1:0]      s_ARBURST_o;
  logic [2:0]      s_ARLEN_o;
  logic [2:0]      s_ARSIZE_o;
  logic            s_ARVALID_o;
  logic            s_ARREADY_i;
  logic [IW-1:0]   s_RID_i;
  logic [DW-1:0]   s_RDATA_i;
  logic [1:0]      s_RRESP_i;
  logic            s_RLAST_i;
  logic            s_RVALID_i;
  logic            s_RREADY_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 ACLK_i = ~ACLK_i;

  sa_read_channel dut (
    .ACLK_i              (ACLK_i),
    .ARESETn_i           (ARESETn_i),
    .dsp_ARID_i          (dsp_ARID_i),
    .dsp_ARADDR_i        (dsp_ARADDR_i),
    .dsp_ARBURST_i       (dsp_ARBURST_i),
    .dsp_ARLEN_i         (dsp_ARLEN_i),
    .dsp_ARSIZE_i        (dsp_ARSIZE_i),
    .dsp_ARVALID_i       (dsp_ARVALID_i),
    .dsp_AR_outst_full_i (dsp_AR_outst_full_i),
    .dsp_ARREADY_o       (dsp_ARREADY_o),
    .dsp_RID_o           (dsp_RID_o),
    .dsp_RDATA_o         (dsp_RDATA_o),
    .dsp_RRESP_o         (dsp_RRESP_o),
    .dsp_RLAST_o         (dsp_RLAST_o),
    .dsp_RVALID_o        (dsp_RVALID_o),
    .dsp_RREADY_i        (dsp_RREADY_i),
    .s_ARID_o            (s_ARID_o),
    .s_ARADDR_o          (s_ARADDR_o),
    .s_ARBURST_o         (s_ARBURST_o),
    .s_ARLEN_o           (s_ARLEN_o),
    .s_ARSIZE_o          (s_ARSIZE_o),
    .s_ARVALID_o         (s_ARVALID_o),
    .s_ARREADY_i         (s_ARREADY_i),
    .s_RID_i             (s_RID_i),
    .s_RDATA_i           (s_RDATA_i),
    .s_RRESP_i           (s_RRESP_i),
    .s_RLAST_i           (s_RLAST_i),
    .s_RVALID_i          (s_RVALID_i),
    .s_RREADY_o          (s_RREADY_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    dsp_ARID_i          = '0;
    dsp_ARADDR_i        = '0;
    dsp_ARBURST_i       = '0;
    dsp_ARLEN_i         = '0;
    dsp_ARSIZE_i        = '0;
    dsp_ARVALID_i       = '0;
    dsp_AR_outst_full_i = '0;
    dsp_RREADY_i        = '0;
    s_ARREADY_i         = 1'b0;
    s_RID_i             = '0;
    s_RDATA_i           = '0;
    s_RRESP_i           = '0;
    s_RLAST_i           = 1'b0;
    s_RVALID_i          = 1'b0;
  endtask

  task automatic do_reset();
    ARESETn_i = 1'b0;
    clear_inputs();
    repeat (2) @(posedge ACLK_i);
    #1;
    ARESETn_i = 1'b1;
  endtask

  task automatic set_ar(input int m, input logic [31:0] addr, input logic [2:0] len,
                        input logic [4:0] id);
    dsp_ARADDR_i[m*AW +: AW] = addr;
    dsp_ARLEN_i[m*3 +: 3]    = len;
    dsp_ARID_i[m*IW +: IW]   = id;
  endtask

  // Returns at the negedge of the first cycle with any ARREADY set; 0 on timeout.
  task automatic wait_grant(output logic [M-1:0] g);
    g = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK_i);
      if (dsp_ARREADY_o != '0) begin
        g = dsp_ARREADY_o;
        return;
      end
    end
  endtask

  logic [M-1:0] g;
  int           gcnt;

  initial begin
    // Reset state, including an owner-less R beat and a pending AR.
    ARESETn_i = 1'b0;
    clear_inputs();
    dsp_ARVALID_i = 2'b01;
    s_RVALID_i    = 1'b1;
    dsp_RREADY_i  = 2'b11;
    #3;
    check("rst_arready", dsp_ARREADY_o, 2'b00);
    check("rst_s_arvalid", s_ARVALID_o, 1'b0);
    check("rst_s_rready", s_RREADY_o, 1'b0);
    check("rst_dsp_rvalid", dsp_RVALID_o, 2'b00);

    // Single AR from m1, 4-beat burst.
    do_reset();
    set_ar(1, 32'h4000_0010, 3'd3, 5'd5);
    dsp_ARVALID_i = 2'b10;
    s_ARREADY_i   = 1'b1;
    wait_grant(g);
    check("t1_grant", g, 2'b10);
    @(posedge ACLK_i); #1;
    dsp_ARVALID_i = 2'b00;
    @(negedge ACLK_i);
    check("t1_s_arvalid", s_ARVALID_o, 1'b1);
    check("t1_s_araddr", s_ARADDR_o, 32'h4000_0010);
    check("t1_s_arlen", s_ARLEN_o, 3'd3);
    check("t1_s_arid", s_ARID_o, 5'd5);
    check("t1_hold_noready", dsp_ARREADY_o, 2'b00);
    @(negedge ACLK_i);
    check("t1_s_arvalid_drop", s_ARVALID_o, 1'b0);
    @(posedge ACLK_i); #1;
    for (int b = 0; b < 4; b++) begin
      s_RVALID_i   = 1'b1;
      s_RDATA_i    = 32'hA0 + 32'(b);
      s_RLAST_i    = (b == 3);
      dsp_RREADY_i = 2'b11;
      @(negedge ACLK_i);
      check("t1_rvalid", dsp_RVALID_o, 2'b10);
      check("t1_s_rready", s_RREADY_o, 1'b1);
      check("t1_rdata_m1", dsp_RDATA_o[DW +: DW], 32'hA0 + 32'(b));
      @(posedge ACLK_i); #1;
    end
    s_RLAST_i = 1'b0;
    @(negedge ACLK_i);
    check("t1_popped_rready", s_RREADY_o, 1'b0);
    check("t1_popped_rvalid", dsp_RVALID_o, 2'b00);
    s_RVALID_i = 1'b0;

    // Both masters continuously valid: alternate grants from m0.
    do_reset();
    set_ar(0, 32'h0000_1000, 3'd0, 5'd1);
    set_ar(1, 32'h0000_2000, 3'd0, 5'd2);
    dsp_ARVALID_i = 2'b11;
    s_ARREADY_i   = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_grant(g);
      check("t2_grant", g, (k % 2) ? 2'b10 : 2'b01);
      @(negedge ACLK_i);
      check("t2_s_arvalid", s_ARVALID_o, 1'b1);
      check("t2_s_araddr", s_ARADDR_o, (k % 2) ? 32'h2000 : 32'h1000);
    end
    dsp_ARVALID_i = 2'b00;

    // Outstanding-full on m0 excludes it; releasing it lets m0 win next.
    do_reset();
    dsp_AR_outst_full_i = 2'b01;
    dsp_ARVALID_i       = 2'b11;
    s_ARREADY_i         = 1'b1;
    wait_grant(g);
    check("t3_grant_a", g, 2'b10);
    wait_grant(g);
    check("t3_grant_b", g, 2'b10);
    @(posedge ACLK_i); #1;
    dsp_AR_outst_full_i = 2'b00;
    wait_grant(g);
    check("t3_grant_release", g, 2'b01);
    dsp_ARVALID_i = 2'b00;

    // FIFO full after 8 ARs; one RLAST pop frees a slot.
    do_reset();
    dsp_ARVALID_i = 2'b01;
    s_ARREADY_i   = 1'b1;
    gcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge ACLK_i);
      if (dsp_ARREADY_o[0]) gcnt++;
    end
    check("t4_accepted", 64'(gcnt), 64'd8);
    check("t4_ninth_blocked", dsp_ARREADY_o, 2'b00);
    s_RVALID_i   = 1'b1;
    s_RLAST_i    = 1'b1;
    dsp_RREADY_i = 2'b01;
    #1;
    check("t4_rvalid", dsp_RVALID_o, 2'b01);
    check("t4_s_rready", s_RREADY_o, 1'b1);
    @(posedge ACLK_i); #1;
    s_RVALID_i = 1'b0;
    s_RLAST_i  = 1'b0;
    @(negedge ACLK_i);
    check("t4_ninth_granted", dsp_ARREADY_o, 2'b01);
    @(posedge ACLK_i); #1;
    dsp_ARVALID_i = 2'b00;

    // Master R backpressure on the last beat: stall, data held, no pop.
    do_reset();
    set_ar(0, 32'h0000_3000, 3'd1, 5'd3);
    dsp_ARVALID_i = 2'b01;
    s_ARREADY_i   = 1'b1;
    wait_grant(g);
    @(posedge ACLK_i); #1;
    dsp_ARVALID_i = 2'b00;
    @(posedge ACLK_i); #1;
    s_RVALID_i   = 1'b1;
    s_RDATA_i    = 32'h11;
    s_RLAST_i    = 1'b0;
    dsp_RREADY_i = 2'b01;
    @(negedge ACLK_i);
    check("t5_beat0_rready", s_RREADY_o, 1'b1);
    @(posedge ACLK_i); #1;
    s_RDATA_i    = 32'h22;
    s_RLAST_i    = 1'b1;
    dsp_RREADY_i = 2'b00;
    for (int c = 0; c < 3; c++) begin
      @(negedge ACLK_i);
      check("t5_stall_rready", s_RREADY_o, 1'b0);
      check("t5_stall_rvalid", dsp_RVALID_o, 2'b01);
      check("t5_stall_rdata", dsp_RDATA_o[0 +: DW], 32'h22);
      @(posedge ACLK_i); #1;
    end
    dsp_RREADY_i = 2'b01;
    @(negedge ACLK_i);
    check("t5_release_rready", s_RREADY_o, 1'b1);
    @(posedge ACLK_i); #1;
    @(negedge ACLK_i);
    check("t5_after_pop_rready", s_RREADY_o, 1'b0);
    s_RVALID_i = 1'b0;
    s_RLAST_i  = 1'b0;

    // Reset in HOLD with two FIFO entries.
    do_reset();
    set_ar(0, 32'h0000_5000, 3'd0, 5'd4);
    dsp_ARVALID_i = 2'b01;
    s_ARREADY_i   = 1'b1;
    wait_grant(g);
    wait_grant(g);
    wait_grant(g);
    s_ARREADY_i = 1'b0;
    @(negedge ACLK_i);
    check("t6_hold_valid", s_ARVALID_o, 1'b1);
    @(negedge ACLK_i);
    check("t6_hold_valid2", s_ARVALID_o, 1'b1);
    check("t6_hold_addr", s_ARADDR_o, 32'h5000);
    #1;
    ARESETn_i    = 1'b0;
    s_RVALID_i   = 1'b1;
    dsp_RREADY_i = 2'b01;
    #1;
    check("t6_rst_arvalid", s_ARVALID_o, 1'b0);
    check("t6_rst_arready", dsp_ARREADY_o, 2'b00);
    check("t6_rst_araddr", s_ARADDR_o, 32'h0);
    check("t6_rst_rready", s_RREADY_o, 1'b0);
    dsp_ARVALID_i = 2'b00;
    @(posedge ACLK_i); #1;
    ARESETn_i = 1'b1;
    @(negedge ACLK_i);
    check("t6_post_rready", s_RREADY_o, 1'b0);
    check("t6_post_rvalid", dsp_RVALID_o, 2'b00);
    s_RVALID_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
